tlm_mem_slave: RTL
==================

// Module: tlm_mem_slave
// PURPOSE
//  Handshaked, byte-enabled word memory that sits directly downstream of the SHUNT TLM Target.
//  Consumes one decoded generic-payload request at a time (cmd/addr/data/byte-enable/id).
//  Performs the access after a programmable number of wait states.
//  Returns one response per request (read data, TLM-style status, id) over a valid/ready channel.
//  Replaces the free-running bare memory so the Target can back-pressure and see error status.
// PARAMETERS
//  DEPTH     256           number of DATA_W words; legal word addresses 0..DEPTH-1
//  ADDR_W    32            request address width (word address)
//  DATA_W    32            data width, multiple of 8
//  ID_W      4             transaction id width (carries AxID)
//  WAIT_CYC  1             extra access cycles, 0..15
//  INIT_VAL  32'hAA000000  time-zero content of every word (not touched by reset)
// PORTS
//  clk_i         in   1         clock; all state updates on posedge
//  rst_n_i       in   1         asynchronous active-low reset
//  req_valid_i   in   1         request valid
//  req_ready_o   out  1         request ready
//  req_cmd_i     in   2         0 READ, 1 WRITE, 2 IGNORE, 3 illegal
//  req_addr_i    in   ADDR_W    word address
//  req_wdata_i   in   DATA_W    write data
//  req_be_i      in   DATA_W/8  byte enables, bit i -> byte i
//  req_id_i      in   ID_W      id, echoed in response
//  rsp_valid_o   out  1         response valid
//  rsp_ready_i   in   1         response ready
//  rsp_rdata_o   out  DATA_W    read data; 0 for non-read or error
//  rsp_status_o  out  2         0 OK, 1 ADDRESS_ERROR, 2 COMMAND_ERROR, 3 reserved
//  rsp_id_o      out  ID_W      id of the completed request
// BEHAVIOUR
//  - Reset (rst_n_i low, async): state IDLE, wait counter 0, rsp_valid_o 0, rsp_rdata_o 0,
//    rsp_status_o 0, rsp_id_o 0.
//    req_ready_o = (state==IDLE), so it reads 1 from the first cycle after reset release.
//  - FSM: IDLE -> ACCESS on req_valid_i && req_ready_o (accept edge N).
//    Inputs are sampled only at the accept edge; later changes are ignored.
//  - ACCESS lasts WAIT_CYC+1 cycles, counted by a 4-bit down-counter loaded with WAIT_CYC.
//    At the edge where the counter is 0:
//    - the write is committed,
//    - read data and status are registered,
//    - rsp_valid_o rises; state -> RESP.
//    Net effect: rsp_valid_o is first high in cycle N+WAIT_CYC+1.
//  - RESP: rsp_* stay stable until rsp_valid_o && rsp_ready_i.
//    On that edge: rsp_valid_o <= 0, state -> IDLE.
//    No same-cycle re-accept; peak throughput is 1 request per WAIT_CYC+3 cycles.
//  - Address check: req_addr_i >= DEPTH -> ADDRESS_ERROR, no memory access.
//    No wrap and no truncation of upper bits.
//  - Command check: cmd 3 -> COMMAND_ERROR, no access. cmd 2 -> OK, no access, rdata 0.
//  - Priority: COMMAND_ERROR over ADDRESS_ERROR.
//  - WRITE: only bytes with be=1 are updated. be=0 is a legal no-op returning OK.
//  - READ: rsp_rdata_o byte i = mem byte i if be[i], else 8'h00.
//  - Reset mid-ACCESS: transaction dropped, no response; a pending write is NOT committed.
//    Reset mid-RESP: response lost.
//  - Memory array is never cleared by reset.
// STRUCTURE
//  - tlm_mem_pkg holds:
//    - tlm_mem_cmd_e {READ, WRITE, IGNORE}
//    - tlm_mem_status_e {OK, ADDRESS_ERROR, COMMAND_ERROR}
//    - CMD_W=2, STATUS_W=2
//    - FSM state enum {IDLE, ACCESS, RESP}
//  - One sub-module, tlm_mem_array: single-port synchronous RAM, DEPTH x DATA_W.
//    Per-byte write enable, registered read, INIT_VAL preload.
//    The top level holds the FSM, counter, checks and response registers.
// TESTING (DEPTH=256, WAIT_CYC=1 unless noted)
//  1. WRITE addr 5, data DEADBEEF, be F, id 3 -> rsp_valid 2 cycles after accept, OK, id 3,
//     rdata 0. Then READ addr 5, be F -> rdata DEADBEEF.
//  2. WRITE addr 5, data 11223344, be 3 -> OK. READ addr 5, be F -> DEAD3344.
//     READ addr 5, be 4 -> 00AD0000.
//  3. READ addr 256 -> ADDRESS_ERROR, rdata 0. WRITE addr FFFFFFFF -> ADDRESS_ERROR.
//     READ of addr 255 still returns its prior value.
//  4. cmd 3, addr 999 -> COMMAND_ERROR. cmd 2, addr 5 -> OK, rdata 0, addr 5 unchanged.
//  5. rsp_ready_i held low 10 cycles -> rsp_* stable, req_ready_o 0, second request waits.
//     Second request is accepted 1 cycle after the handshake.
//     Repeat with WAIT_CYC=0 and WAIT_CYC=15 to check latency 1 and 16.
//  6. rst_n_i low during ACCESS of WRITE addr 7, data 12345678 -> rsp_valid_o 0 immediately.
//     After release: req_ready_o 1; READ addr 7 returns the pre-write value.

Source files
------------

// File: rtl/tlm_mem_pkg.sv
// tlm_mem_pkg
//   Shared types for the handshaked TLM memory slave: command and status
//   encodings as they appear on the request/response channels, plus the
//   slave's FSM state encoding. There are no ports; every other file in this
//   slice imports the package.

package tlm_mem_pkg;

  localparam int CMD_W    = 2;
  localparam int STATUS_W = 2;

  // Command code 3 is deliberately absent. The slave answers it with
  // COMMAND_ERROR.
  typedef enum logic [CMD_W-1:0] {
    READ   = 2'd0,
    WRITE  = 2'd1,
    IGNORE = 2'd2
  } tlm_mem_cmd_e;

  // Status code 3 is reserved and the slave never produces it.
  typedef enum logic [STATUS_W-1:0] {
    OK            = 2'd0,
    ADDRESS_ERROR = 2'd1,
    COMMAND_ERROR = 2'd2
  } tlm_mem_status_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } tlm_mem_state_e;

endpackage

// File: rtl/tlm_mem_array.sv
// tlm_mem_array
//   Single-port synchronous RAM of DEPTH x DATA_W words with per-byte write
//   enables and a registered read port. Every word holds INIT_VAL from time
//   zero. No reset reaches the storage.
// Ports
//   clk_i    in   1         clock
//   en_i     in   1         port enable; a read or a write happens only when high
//   we_i     in   1         1 = write the enabled bytes, 0 = read into rdata_o
//   be_i     in   DATA_W/8  byte write enables, bit i -> byte i
//   addr_i   in   AW        word address, must be < DEPTH when used
//   wdata_i  in   DATA_W    write data
//   rdata_o  out  DATA_W    read data, valid the cycle after a read and held until the next read

module tlm_mem_array #(
  parameter int                DEPTH    = 256,
  parameter int                DATA_W   = 32,
  parameter int                AW       = 8,
  parameter logic [DATA_W-1:0] INIT_VAL = 32'hAA000000
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [DATA_W/8-1:0]   be_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o
);

  localparam int BE_W = DATA_W / 8;

  // The declaration initialiser gives the power-up contents. The RAM has no
  // reset port, so a reset does not clear it.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT_VAL};

  // A write does not change rdata_o. The last read value stays visible.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_o <= mem[addr_i];
      end
    end
  end

endmodule

// File: rtl/tlm_mem_slave.sv
// tlm_mem_slave
//   Byte-enabled word memory that sits behind the TLM target. It takes one
//   request at a time and waits WAIT_CYC extra access cycles. Then it returns
//   one response with read data, a TLM-style status and the echoed id.
// Ports
//   clk_i         in   1         clock
//   rst_n_i       in   1         asynchronous active-low reset
//   req_valid_i   in   1         request valid
//   req_ready_o   out  1         request ready (high only in IDLE)
//   req_cmd_i     in   2         0 READ, 1 WRITE, 2 IGNORE, 3 illegal
//   req_addr_i    in   ADDR_W    word address
//   req_wdata_i   in   DATA_W    write data
//   req_be_i      in   DATA_W/8  byte enables
//   req_id_i      in   ID_W      id, echoed in the response
//   rsp_valid_o   out  1         response valid
//   rsp_ready_i   in   1         response ready
//   rsp_rdata_o   out  DATA_W    read data; 0 for non-read or error
//   rsp_status_o  out  2         0 OK, 1 ADDRESS_ERROR, 2 COMMAND_ERROR
//   rsp_id_o      out  ID_W      id of the completed request
//   dbg_state_o   out  2         current FSM state (IDLE/ACCESS/RESP encoding)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer keeps valid and its payload stable until that
// transfer, and ready never depends on the same channel's valid. Request
// fields are sampled only on the accept edge. Response fields stay constant
// from the moment rsp_valid_o rises until the response handshake.

module tlm_mem_slave
  import tlm_mem_pkg::*;
#(
  parameter int                DEPTH    = 256,
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                ID_W     = 4,
  parameter int                WAIT_CYC = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = 32'hAA000000
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [CMD_W-1:0]      req_cmd_i,
  input  logic [ADDR_W-1:0]     req_addr_i,
  input  logic [DATA_W-1:0]     req_wdata_i,
  input  logic [DATA_W/8-1:0]   req_be_i,
  input  logic [ID_W-1:0]       req_id_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_W-1:0]     rsp_rdata_o,
  output logic [STATUS_W-1:0]   rsp_status_o,
  output logic [ID_W-1:0]       rsp_id_o,
  output logic [1:0]            dbg_state_o
);

  localparam int BE_W = DATA_W / 8;
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  tlm_mem_state_e    state;
  logic [3:0]        wait_cnt;
  logic [CMD_W-1:0]  cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [ID_W-1:0]   id_q;

  tlm_mem_status_e   status_c;
  logic [DATA_W-1:0] rdata_c;
  logic              accept;
  logic              finish;
  logic              mem_en;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  assign req_ready_o = (state == IDLE);
  assign dbg_state_o = state;
  assign accept      = req_valid_i && req_ready_o;
  assign finish      = (state == ACCESS) && (wait_cnt == 4'd0);

  // Checks run on the captured request. An illegal command takes priority
  // over a bad address. The full address is compared, so a large address
  // never wraps into the array.
  always_comb begin
    status_c = OK;
    if (cmd_q == 2'd3) begin
      status_c = COMMAND_ERROR;
    end else if (addr_q >= ADDR_W'(DEPTH)) begin
      status_c = ADDRESS_ERROR;
    end
  end

  // The RAM read starts on the accept edge using the live request address.
  // The registered RAM output is then ready at the completion edge, even when
  // WAIT_CYC is 0. An out-of-range read fetches a harmless aliased word,
  // and the status check discards it below.
  assign mem_we   = finish && (cmd_q == WRITE) && (status_c == OK);
  assign mem_en   = accept || mem_we;
  assign mem_addr = mem_we ? addr_q[AW-1:0] : req_addr_i[AW-1:0];

  always_comb begin
    rdata_c = '0;
    if ((cmd_q == READ) && (status_c == OK)) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_q[b]) rdata_c[8*b +: 8] = mem_rdata[8*b +: 8];
      end
    end
  end

  tlm_mem_array #(
    .DEPTH    (DEPTH),
    .DATA_W   (DATA_W),
    .AW       (AW),
    .INIT_VAL (INIT_VAL)
  ) u_array (
    .clk_i   (clk_i),
    .en_i    (mem_en),
    .we_i    (mem_we),
    .be_i    (be_q),
    .addr_i  (mem_addr),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

  // A write commits only on the completion edge. A reset during ACCESS
  // therefore leaves memory untouched.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      wait_cnt     <= 4'd0;
      cmd_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      id_q         <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_rdata_o  <= '0;
      rsp_status_o <= '0;
      rsp_id_o     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            cmd_q    <= req_cmd_i;
            addr_q   <= req_addr_i;
            wdata_q  <= req_wdata_i;
            be_q     <= req_be_i;
            id_q     <= req_id_i;
            wait_cnt <= 4'(WAIT_CYC);
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (wait_cnt == 4'd0) begin
            rsp_valid_o  <= 1'b1;
            rsp_rdata_o  <= rdata_c;
            rsp_status_o <= status_c;
            rsp_id_o     <= id_q;
            state        <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
